// File: rtl/ycbcr_to_rgb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ycbcr_to_rgb                                                               |
// | Full-range BT.601 YCbCr -> 8-bit RGB over AXI4-Stream, 3-stage pipeline.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ycbcr_to_rgb (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Sel,
  input  logic [23:0] Sel_YCbCr,
  input  logic [23:0] s_axis_video_tdata,
  input  logic        s_axis_video_tvalid,
  output logic        s_axis_video_tready,
  input  logic        s_axis_video_tlast,
  input  logic        s_axis_video_tuser,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser
);

  localparam logic signed [18:0] c_KRCR = 19'sd359;
  localparam logic signed [18:0] c_KGCB = 19'sd88;
  localparam logic signed [18:0] c_KGCR = 19'sd183;
  localparam logic signed [18:0] c_KBCB = 19'sd454;
  localparam logic signed [18:0] c_RND  = 19'sd128;
  localparam logic        [8:0]  c_OFS  = 9'd128;

  logic               w_adv1, w_adv2, w_adv3, w_accept;
  logic        [23:0] w_pix;
  logic signed [8:0]  w_dcb, w_dcr;
  logic signed [18:0] w_dcb_x, w_dcr_x, w_y_x;
  logic signed [18:0] w_rcr, w_gcb, w_gcr, w_bcb;

  logic               r_v1, r_last1, r_user1;
  logic signed [18:0] r_y1, r_rcr1, r_gcb1, r_gcr1, r_bcb1;
  logic               r_v2, r_last2, r_user2;
  logic signed [18:0] r_sr2, r_sg2, r_sb2;
  logic               r_v3, r_last3, r_user3;
  logic        [23:0] r_data3;

  // Bubble-collapsing handshake: a stage may load whenever it is empty or
  // the stage after it is moving.
  assign w_adv3   = !r_v3 | m_axis_video_tready;
  assign w_adv2   = !r_v2 | w_adv3;
  assign w_adv1   = !r_v1 | w_adv2;
  assign w_accept = s_axis_video_tvalid & w_adv1;
  assign s_axis_video_tready = w_adv1;

  assign w_pix   = Sel ? Sel_YCbCr : s_axis_video_tdata;
  assign w_dcb   = $signed({1'b0, w_pix[15:8]} - c_OFS);
  assign w_dcr   = $signed({1'b0, w_pix[23:16]} - c_OFS);
  assign w_dcb_x = {{10{w_dcb[8]}}, w_dcb};
  assign w_dcr_x = {{10{w_dcr[8]}}, w_dcr};
  assign w_y_x   = $signed({3'b000, w_pix[7:0], 8'h00});
  assign w_rcr   = w_dcr_x * c_KRCR;
  assign w_gcb   = w_dcb_x * c_KGCB;
  assign w_gcr   = w_dcr_x * c_KGCR;
  assign w_bcb   = w_dcb_x * c_KBCB;

  // Negative sums clamp to 0, anything at or above 256.0 clamps to 255.
  function automatic logic [7:0] f_clamp(input logic signed [18:0] s);
    logic [7:0] v;
    if (s[18])
      v = 8'h00;
    else if (|s[17:16])
      v = 8'hFF;
    else
      v = s[15:8];
    return v;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_user1 <= 1'b0;
      r_y1    <= '0;
      r_rcr1  <= '0;
      r_gcb1  <= '0;
      r_gcr1  <= '0;
      r_bcb1  <= '0;
    end else if (w_adv1) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_last1 <= s_axis_video_tlast;
        r_user1 <= s_axis_video_tuser;
        r_y1    <= w_y_x;
        r_rcr1  <= w_rcr;
        r_gcb1  <= w_gcb;
        r_gcr1  <= w_gcr;
        r_bcb1  <= w_bcb;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_user2 <= 1'b0;
      r_sr2   <= '0;
      r_sg2   <= '0;
      r_sb2   <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_last2 <= r_last1;
        r_user2 <= r_user1;
        r_sr2   <= r_y1 + r_rcr1 + c_RND;
        r_sg2   <= r_y1 - r_gcb1 - r_gcr1 + c_RND;
        r_sb2   <= r_y1 + r_bcb1 + c_RND;
      end
    end
  end

  // Output register only changes when empty or consumed, keeping AXI data stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v3    <= 1'b0;
      r_last3 <= 1'b0;
      r_user3 <= 1'b0;
      r_data3 <= '0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_last3 <= r_last2;
        r_user3 <= r_user2;
        r_data3 <= {f_clamp(r_sr2), f_clamp(r_sb2), f_clamp(r_sg2)};
      end
    end
  end

  assign m_axis_video_tvalid = r_v3;
  assign m_axis_video_tdata  = r_data3;
  assign m_axis_video_tlast  = r_last3;
  assign m_axis_video_tuser  = r_user3;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_to_rgb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ycbcr_to_rgb                                                            |
// | Scoreboard bench for the YCbCr -> RGB AXI4-Stream converter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ycbcr_to_rgb;

  logic        clk;
  logic        rstn;
  logic        sel;
  logic [23:0] sel_ycbcr;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;

  ycbcr_to_rgb u_dut (
    .clk                 (clk),
    .rstn                (rstn),
    .Sel                 (sel),
    .Sel_YCbCr           (sel_ycbcr),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tready (s_tready),
    .s_axis_video_tlast  (s_tlast),
    .s_axis_video_tuser  (s_tuser),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tready (m_tready),
    .m_axis_video_tlast  (m_tlast),
    .m_axis_video_tuser  (m_tuser)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {tlast, tuser, R, B, G}
  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int occ = 0;
  int acc_cyc = 0;
  int out_cyc = -1;
  int stall_viol = 0;
  int rdy_viol = 0;
  int rdy_low_cnt = 0;
  bit rdy_toggle = 1'b0;
  bit prev_stall = 1'b0;
  logic [25:0] prev_beat;
  bit acc, emt;

  function automatic logic [7:0] clamp8(input int s);
    if (s < 0) return 8'h00;
    if (s / 256 > 255) return 8'hFF;
    return 8'(s / 256);
  endfunction

  function automatic logic [25:0] model(input logic [23:0] px, input logic l, input logic u);
    int y, dcb, dcr;
    logic [7:0] r, g, b;
    y   = int'(px[7:0]);
    dcb = int'(px[15:8]) - 128;
    dcr = int'(px[23:16]) - 128;
    r = clamp8(y * 256 + 359 * dcr + 128);
    g = clamp8(y * 256 - 88 * dcb - 183 * dcr + 128);
    b = clamp8(y * 256 + 454 * dcb + 128);
    return {l, u, r, b, g};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_toggle) m_tready = ~m_tready;
  end

  // Observes handshakes mid-cycle; the transfer commits on the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      acc = s_tvalid && s_tready;
      emt = m_tvalid && m_tready;
      if (s_tready !== !(occ == 3 && !m_tready)) rdy_viol++;
      if (!s_tready) rdy_low_cnt++;
      if (prev_stall && (!m_tvalid || {m_tlast, m_tuser, m_tdata} !== prev_beat)) stall_viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tuser, m_tdata};
      if (m_tvalid && out_cyc < 0) out_cyc = cyc;
      if (acc) begin
        exp_q.push_back(model(sel ? sel_ycbcr : s_tdata, s_tlast, s_tuser));
        acc_cyc = cyc;
      end
      if (emt) obs_q.push_back({m_tlast, m_tuser, m_tdata});
      occ = occ + int'(acc) - int'(emt);
    end
  end

  task automatic send(input logic [23:0] d, input logic l, input logic u);
    int w;
    w = 0;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: s_tready stayed %b, required 1", s_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit to);
    int w;
    w = 0;
    while (occ != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    to = (occ != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; sel = 1'b0; sel_ycbcr = '0; s_tdata = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 24'h000000) begin n_err++; $display("FAIL reset_tdata: got %h required 000000", m_tdata); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b required 0", m_tlast); end
    n_cmp++; if (m_tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser: got %b required 0", m_tuser); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready: got %b required 1", s_tready); end
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_grey;
    bit to;
    out_cyc = -1;
    m_tready = 1'b1;
    send(24'h808080, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    drain(to);
    n_cmp++; if (to || obs_q.size() != 1) begin n_err++; $display("FAIL grey_count: got %0d required 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      n_cmp++; if (obs_q[0] !== 26'h0808080) begin n_err++; $display("FAIL grey_data: got %h required 0808080", obs_q[0]); end
    end
    n_cmp++; if (out_cyc - acc_cyc != 3) begin n_err++; $display("FAIL grey_latency: got %0d required 3", out_cyc - acc_cyc); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_colors;
    logic [23:0] vin  [3];
    logic [23:0] vout [3];
    bit to;
    vin  = '{24'hFF554C, 24'h000000, 24'hFFFFFF};
    vout = '{24'hFE0000, 24'h000088, 24'hFFFF79};
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(vin[i], 1'b0, 1'b0);
    s_tvalid = 1'b0;
    drain(to);
    n_cmp++; if (to || obs_q.size() != 3) begin n_err++; $display("FAIL colors_count: got %0d required 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i][23:0] !== vout[i] || obs_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL colors[%0d]: got %h required %h", i, obs_q[i][23:0], vout[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    int low0;
    bit to;
    low0 = rdy_low_cnt;
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) send(24'($urandom), 1'($urandom), 1'($urandom));
    s_tvalid = 1'b0;
    drain(to);
    n_cmp++; if (rdy_low_cnt != low0) begin n_err++; $display("FAIL b2b_tready_low: got %0d cycles required 0", rdy_low_cnt - low0); end
    n_cmp++; if (to || obs_q.size() != 6) begin n_err++; $display("FAIL b2b_count: got %0d required 6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure;
    int sv0, rv0, low0;
    bit to;
    sv0 = stall_viol; rv0 = rdy_viol; low0 = rdy_low_cnt;
    rdy_toggle = 1'b1;
    for (int i = 0; i < 8; i++) send(24'($urandom), (i == 7), (i == 0));
    s_tvalid = 1'b0;
    rdy_toggle = 1'b0;
    m_tready = 1'b1;
    drain(to);
    n_cmp++; if (to || obs_q.size() != 8) begin n_err++; $display("FAIL bp_count: got %0d required 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][25] !== (i == 7) || obs_q[i][24] !== (i == 0)) begin
        n_err++; $display("FAIL bp[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++; if (stall_viol != sv0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles required 0", stall_viol - sv0); end
    n_cmp++; if (rdy_viol != rv0) begin n_err++; $display("FAIL bp_tready: got %0d wrong cycles required 0", rdy_viol - rv0); end
    n_cmp++; if (rdy_low_cnt == low0) begin n_err++; $display("FAIL bp_full: got 0 tready-low cycles required >0"); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_override;
    bit to;
    m_tready = 1'b1;
    sel = 1'b1;
    sel_ycbcr = 24'h808080;
    for (int i = 0; i < 4; i++) send(24'($urandom), (i == 3), (i == 0));
    s_tvalid = 1'b0;
    sel = 1'b0;
    drain(to);
    n_cmp++; if (to || obs_q.size() != 4) begin n_err++; $display("FAIL ovr_count: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== {(i == 3), (i == 0), 24'h808080}) begin
        n_err++; $display("FAIL ovr[%0d]: got %h required %h", i, obs_q[i], {(i == 3), (i == 0), 24'h808080});
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midstream;
    bit to;
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(24'h10F0A0 + 24'(i), 1'b1, 1'b1);
    s_tvalid = 1'b0;
    n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL mid_inflight: got tvalid %b required 1", m_tvalid); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_async_tvalid: got %b required 0", m_tvalid); end
    exp_q.delete(); obs_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL mid_tready: got %b required 1", s_tready); end
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    send(24'h808080, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    drain(to);
    n_cmp++; if (to || obs_q.size() != 1) begin n_err++; $display("FAIL mid_count: got %0d required 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++; if (obs_q[0] !== 26'h0808080) begin n_err++; $display("FAIL mid_data: got %h required 0808080", obs_q[0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_grey();
    test_colors();
    test_back_to_back();
    test_backpressure();
    test_override();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
